pri_arbiter_hold: RTL and testbench

- 16-requester fixed-priority arbiter. Lowest set request index wins, so bit 0 has the highest priority.
- Grants are registered and held until the holder releases its request, a hold timeout fires, or the block is disabled.
- Sits in front of a shared resource and gives it exactly one owner at a time.
- A timed-out holder is skipped for one arbitration round, so it cannot starve lower-priority requesters.

---
 rtl/pri_arbiter_pkg.sv | 16 +
 rtl/pri_encoder_lsb.sv | 22 ++
 rtl/pri_arbiter_hold.sv | 155 +++++++++++++++
 tb/tb_pri_arbiter_hold.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pri_arbiter_pkg.sv
// Shared defaults, counter width and state encoding for the hold-grant arbiter.
package pri_arbiter_pkg;

   localparam int unsigned DEF_N        = 16;
   localparam int unsigned DEF_IDW      = 4;
   localparam int unsigned DEF_MAX_HOLD = 8;
   localparam int unsigned HOLD_CNT_W   = 8;

   // 2'd3 is unused and recovers to IDLE.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

endpackage

// File: rtl/pri_encoder_lsb.sv
// Combinational priority encoder: index of the lowest set bit of 'in'.
module pri_encoder_lsb #(
   parameter int unsigned N   = 16,
   parameter int unsigned IDW = 4
) (
   input  logic [N-1:0]   in,
   output logic [IDW-1:0] idx,
   output logic           any
);

   // Scan from the top down so the lowest set bit is the last to overwrite idx.
   always_comb begin
      idx = '0;
      any = |in;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (in[i]) begin
            idx = IDW'(i);
         end
      end
   end

endmodule

// File: rtl/pri_arbiter_hold.sv
// Fixed-priority (bit 0 highest) arbiter with held grants, a hold limit and
// one-round skip of a timed-out holder so it cannot starve lower requesters.
module pri_arbiter_hold
   import pri_arbiter_pkg::*;
#(
   parameter int unsigned N        = DEF_N,
   parameter int unsigned IDW      = DEF_IDW,
   parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_valid,
   output logic           hold_timeout
);

   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);

   state_t                state;
   state_t                state_d;
   logic [HOLD_CNT_W-1:0] hold_cnt;
   logic [HOLD_CNT_W-1:0] hold_cnt_d;
   logic                  mask_vld;
   logic                  mask_vld_d;
   logic [IDW-1:0]        mask_id;
   logic [IDW-1:0]        mask_id_d;
   logic [N-1:0]          gnt_d;
   logic [IDW-1:0]        gnt_id_d;
   logic                  gnt_valid_d;
   logic                  hold_timeout_d;

   logic [N-1:0]          masked_req;
   logic [N-1:0]          eligible;
   logic [IDW-1:0]        win_id;
   logic                  win_any;
   logic                  holder_req;
   logic                  at_limit;

   // Drop the masked requester, unless that leaves nobody asking.
   always_comb begin
      masked_req = req;
      if (mask_vld) begin
         masked_req[mask_id] = 1'b0;
      end
      eligible = (masked_req != '0) ? masked_req : req;
   end

   pri_encoder_lsb #(
      .N   (N),
      .IDW (IDW)
   ) u_enc (
      .in  (eligible),
      .idx (win_id),
      .any (win_any)
   );

   assign holder_req = req[gnt_id];
   assign at_limit   = (hold_cnt == HOLD_LAST);

   // Next-state and next-output logic.
   always_comb begin
      state_d        = state;
      gnt_d          = gnt;
      gnt_id_d       = gnt_id;
      gnt_valid_d    = gnt_valid;
      hold_timeout_d = 1'b0;
      hold_cnt_d     = hold_cnt;
      mask_vld_d     = mask_vld;
      mask_id_d      = mask_id;

      case (state)
         IDLE: begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            mask_vld_d  = 1'b0;
            hold_cnt_d  = '0;
            if (enable && win_any) begin
               state_d     = GRANT;
               gnt_d       = N'(1) << win_id;
               gnt_id_d    = win_id;
               gnt_valid_d = 1'b1;
            end
         end

         GRANT: begin
            if (!enable || !holder_req || at_limit) begin
               state_d     = RELEASE;
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
               hold_cnt_d  = '0;
               // Only a pure timeout (holder still asking, still enabled) masks.
               if (enable && holder_req) begin
                  hold_timeout_d = 1'b1;
                  mask_vld_d     = 1'b1;
                  mask_id_d      = gnt_id;
               end else begin
                  mask_vld_d     = 1'b0;
               end
            end else begin
               hold_cnt_d = hold_cnt + HOLD_CNT_W'(1);
            end
         end

         RELEASE: begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            mask_vld_d  = 1'b0;
            hold_cnt_d  = '0;
            if (enable && win_any) begin
               state_d     = GRANT;
               gnt_d       = N'(1) << win_id;
               gnt_id_d    = win_id;
               gnt_valid_d = 1'b1;
            end else begin
               state_d     = IDLE;
            end
         end

         default: begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            mask_vld_d  = 1'b0;
            hold_cnt_d  = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         gnt          <= '0;
         gnt_id       <= '0;
         gnt_valid    <= 1'b0;
         hold_timeout <= 1'b0;
         hold_cnt     <= '0;
         mask_vld     <= 1'b0;
         mask_id      <= '0;
      end else begin
         state        <= state_d;
         gnt          <= gnt_d;
         gnt_id       <= gnt_id_d;
         gnt_valid    <= gnt_valid_d;
         hold_timeout <= hold_timeout_d;
         hold_cnt     <= hold_cnt_d;
         mask_vld     <= mask_vld_d;
         mask_id      <= mask_id_d;
      end
   end

endmodule

// File: tb/tb_pri_arbiter_hold.sv
// Directed bench for pri_arbiter_hold; outputs sampled 1 ns after each rising edge.
module tb_pri_arbiter_hold;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [15:0] req;
   logic [15:0] gnt;
   logic [3:0]  gnt_id;
   logic        gnt_valid;
   logic        hold_timeout;

   logic [21:0] obs;
   int          vectors;
   int          miscompares;

   assign obs = {gnt, gnt_id, gnt_valid, hold_timeout};

   pri_arbiter_hold dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .req          (req),
      .gnt          (gnt),
      .gnt_id       (gnt_id),
      .gnt_valid    (gnt_valid),
      .hold_timeout (hold_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [21:0] exp;
      reset = 1'b1; enable = 1'b0; req = 16'h0000;
      tick; tick;
      exp = {16'h0000, 4'd0, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL reset: got %h need %h", obs, exp); end
      reset = 1'b0;
      tick;
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL idle_disabled: got %h need %h", obs, exp); end
   endtask

   task automatic test_basic_grant;
      logic [21:0] exp;
      enable = 1'b1; req = 16'h0006;
      exp = {16'h0000, 4'd0, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL basic_pre: got %h need %h", obs, exp); end
      tick;
      exp = {16'h0002, 4'd1, 1'b1, 1'b0};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL basic_grant: got %h need %h", obs, exp); end
      tick;
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL basic_hold: got %h need %h", obs, exp); end
   endtask

   task automatic test_holder_drop;
      logic [21:0] exp;
      req = 16'h0004;
      tick;
      exp = {16'h0000, 4'd1, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL drop_gap: got %h need %h", obs, exp); end
      tick;
      exp = {16'h0004, 4'd2, 1'b1, 1'b0};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL drop_regrant: got %h need %h", obs, exp); end
      enable = 1'b0; req = 16'h0000;
      tick;
      exp = {16'h0000, 4'd2, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL disable_release: got %h need %h", obs, exp); end
      tick;
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL idle_id_held: got %h need %h", obs, exp); end
   endtask

   task automatic test_timeout;
      logic [21:0] exp;
      enable = 1'b1; req = 16'h8001;
      for (int c = 1; c <= 19; c++) begin
         tick;
         if (c <= 8)       exp = {16'h0001, 4'd0,  1'b1, 1'b0};
         else if (c == 9)  exp = {16'h0000, 4'd0,  1'b0, 1'b1};
         else if (c <= 17) exp = {16'h8000, 4'd15, 1'b1, 1'b0};
         else if (c == 18) exp = {16'h0000, 4'd15, 1'b0, 1'b1};
         else              exp = {16'h0001, 4'd0,  1'b1, 1'b0};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL timeout cycle %0d: got %h need %h", c, obs, exp);
         end
      end
      enable = 1'b0; req = 16'h0000;
      tick; tick;
   endtask

   task automatic test_lone_timeout;
      logic [21:0] exp;
      enable = 1'b1; req = 16'h0010;
      for (int c = 1; c <= 10; c++) begin
         tick;
         if (c == 9) exp = {16'h0000, 4'd4, 1'b0, 1'b1};
         else        exp = {16'h0010, 4'd4, 1'b1, 1'b0};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL lone_timeout cycle %0d: got %h need %h", c, obs, exp);
         end
      end
      enable = 1'b0; req = 16'h0000;
      tick; tick;
   endtask

   task automatic test_simultaneous;
      logic [21:0] exp;
      enable = 1'b1; req = 16'h0100;
      for (int c = 1; c <= 8; c++) begin
         tick;
         exp = {16'h0100, 4'd8, 1'b1, 1'b0};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL sim_hold_a cycle %0d: got %h need %h", c, obs, exp);
         end
      end
      req = 16'h0000;
      tick;
      exp = {16'h0000, 4'd8, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL drop_at_timeout: got %h need %h", obs, exp); end
      tick;
      req = 16'h0200;
      for (int c = 1; c <= 8; c++) begin
         tick;
         exp = {16'h0200, 4'd9, 1'b1, 1'b0};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL sim_hold_b cycle %0d: got %h need %h", c, obs, exp);
         end
      end
      enable = 1'b0;
      tick;
      exp = {16'h0000, 4'd9, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL disable_at_timeout: got %h need %h", obs, exp); end
      tick; tick;
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL disabled_no_grant: got %h need %h", obs, exp); end
      req = 16'h0000;
   endtask

   task automatic test_enable_drop;
      logic [21:0] exp;
      enable = 1'b1; req = 16'h0008;
      tick;
      exp = {16'h0008, 4'd3, 1'b1, 1'b0};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL en_grant: got %h need %h", obs, exp); end
      tick;
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL en_hold: got %h need %h", obs, exp); end
      enable = 1'b0;
      tick;
      exp = {16'h0000, 4'd3, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL en_drop: got %h need %h", obs, exp); end
      for (int c = 1; c <= 3; c++) begin
         tick;
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL en_blocked cycle %0d: got %h need %h", c, obs, exp);
         end
      end
      enable = 1'b1; req = 16'h0020;
      tick;
      exp = {16'h0020, 4'd5, 1'b1, 1'b0};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL en_regrant: got %h need %h", obs, exp); end
   endtask

   task automatic test_async_reset;
      logic [21:0] exp;
      enable = 1'b0; req = 16'h0000;
      tick; tick;
      enable = 1'b1; req = 16'h0002;
      tick;
      exp = {16'h0002, 4'd1, 1'b1, 1'b0};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL ar_pre: got %h need %h", obs, exp); end
      #2;
      reset = 1'b1;
      #1;
      exp = {16'h0000, 4'd0, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL async_reset: got %h need %h", obs, exp); end
      tick;
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL ar_held: got %h need %h", obs, exp); end
      reset = 1'b0; req = 16'h0001;
      #1;
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL ar_no_early: got %h need %h", obs, exp); end
      tick;
      exp = {16'h0001, 4'd0, 1'b1, 1'b0};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL ar_regrant: got %h need %h", obs, exp); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      enable      = 1'b0;
      req         = 16'h0000;
      test_reset();
      test_basic_grant();
      test_holder_drop();
      test_timeout();
      test_lone_timeout();
      test_simultaneous();
      test_enable_drop();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
